// File: rtl/pwm_cmp_sched.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmp_sched
// Purpose  : Two-channel PWM compare scheduler. Byte writes build 19-bit
//            shadow compares; a control write commits them as targets, and
//            the active compares walk toward their targets one slew-limited
//            step per PWM period_end. Completion raises a W1C status/alert.
// Revision : 1.0  initial release
// ============================================================================
module pwm_cmp_sched #(
  parameter int              CMP_W    = 19,
  parameter logic [CMP_W-1:0] MAX_STEP = 19'h00100,
  parameter logic [CMP_W-1:0] MAX_CMP  = 19'h7FFFF
) (
  input  logic             clk_USB,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [2:0]       rd_addr,
  output logic [7:0]       rd_data,
  input  logic             period_end,
  output logic [CMP_W-1:0] cmpa,
  output logic [CMP_W-1:0] cmpb,
  output logic [1:0]       busy,
  output logic             alert
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SLEW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The byte layout of the register map fixes the compare at 19 bits
  // ({byte2[2:0], byte1, byte0}); channel 0 is A, channel 1 is B.
  logic [1:0][CMP_W-1:0] r_sh;
  logic [1:0][CMP_W-1:0] w_act;
  logic [1:0]            w_busy;
  logic [1:0]            w_done_set;
  logic [1:0]            w_commit;
  logic                  w_imm;
  logic [1:0]            w_w1c;
  logic [1:0]            r_done;

  assign w_commit = (wr_en && wr_addr == 3'd3) ? wr_data[1:0] : 2'b00;
  assign w_imm    = wr_data[7];
  assign w_w1c    = (wr_en && wr_addr == 3'd7) ? wr_data[1:0] : 2'b00;

  // Shadow byte assembly; shadows only feed targets at commit time.
  always_ff @(posedge clk_USB or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0: r_sh[0][7:0]   <= wr_data;
        3'd1: r_sh[0][15:8]  <= wr_data;
        3'd2: r_sh[0][18:16] <= wr_data[2:0];
        3'd4: r_sh[1][7:0]   <= wr_data;
        3'd5: r_sh[1][15:8]  <= wr_data;
        3'd6: r_sh[1][18:16] <= wr_data[2:0];
        default: ;
      endcase
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CMP_W-1:0] r_tgt;
    logic [CMP_W-1:0] r_act;
    logic             r_imm;
    logic [CMP_W-1:0] w_clamp;
    logic [CMP_W-1:0] w_diff;
    logic [CMP_W-1:0] w_step;
    logic [CMP_W-1:0] w_step_act;
    logic             w_apply;

    assign w_clamp = (r_sh[ch] > MAX_CMP) ? MAX_CMP : r_sh[ch];

    // Next active value: jump for immediate, else one bounded step toward target.
    always_comb begin
      w_diff     = (r_tgt >= r_act) ? (r_tgt - r_act) : (r_act - r_tgt);
      w_step     = (w_diff > MAX_STEP) ? MAX_STEP : w_diff;
      w_step_act = r_act;
      if (r_imm) begin
        w_step_act = r_tgt;
      end else if (r_tgt >= r_act) begin
        w_step_act = r_act + w_step;
      end else begin
        w_step_act = r_act - w_step;
      end
    end

    // Next-state logic; a commit overrides any period_end in the same cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_apply     = 1'b0;
      if (w_commit[ch]) begin
        w_state_nxt = ST_PEND;
      end else begin
        case (r_state)
          ST_IDLE: w_state_nxt = ST_IDLE;
          ST_PEND,
          ST_SLEW: begin
            if (period_end) begin
              w_apply     = 1'b1;
              w_state_nxt = (w_step_act == r_tgt) ? ST_DONE : ST_SLEW;
            end
          end
          ST_DONE: w_state_nxt = ST_IDLE;
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    // State, target and active compare registers.
    always_ff @(posedge clk_USB or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_tgt   <= '0;
        r_act   <= '0;
        r_imm   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_commit[ch]) begin
          r_tgt <= w_clamp;
          r_imm <= w_imm;
        end else if (w_apply) begin
          r_act <= w_step_act;
        end
      end
    end

    assign w_act[ch]      = r_act;
    assign w_busy[ch]     = (r_state == ST_PEND) || (r_state == ST_SLEW);
    assign w_done_set[ch] = (r_state == ST_DONE);
  end

  // Done flags: set by a channel's DONE cycle, cleared by W1C; set wins.
  always_ff @(posedge clk_USB or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 2'b00;
    end else begin
      r_done <= (r_done & ~w_w1c) | w_done_set;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_USB or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      case (rd_addr)
        3'd0:    rd_data <= r_sh[0][7:0];
        3'd1:    rd_data <= r_sh[0][15:8];
        3'd2:    rd_data <= {5'b0, r_sh[0][18:16]};
        3'd4:    rd_data <= r_sh[1][7:0];
        3'd5:    rd_data <= r_sh[1][15:8];
        3'd6:    rd_data <= {5'b0, r_sh[1][18:16]};
        3'd7:    rd_data <= {4'b0, w_busy, r_done};
        default: rd_data <= 8'h00;
      endcase
    end
  end

  assign cmpa  = w_act[0];
  assign cmpb  = w_act[1];
  assign busy  = w_busy;
  assign alert = |r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cmp_sched
// Purpose  : Directed self-checking bench for pwm_cmp_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_cmp_sched;

  logic        clk_USB = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'h00;
  logic [2:0]  rd_addr = 3'd0;
  logic [7:0]  rd_data;
  logic        period_end = 1'b0;
  logic [18:0] cmpa;
  logic [18:0] cmpb;
  logic [1:0]  busy;
  logic        alert;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] r_rd;

  pwm_cmp_sched #(
    .CMP_W   (19),
    .MAX_STEP(19'h00100),
    .MAX_CMP (19'h40000)
  ) u_dut (
    .clk_USB   (clk_USB),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .period_end(period_end),
    .cmpa      (cmpa),
    .cmpb      (cmpb),
    .busy      (busy),
    .alert     (alert)
  );

  always #5 clk_USB = ~clk_USB;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_USB);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_USB);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk_USB);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk_USB);
    rd_addr = a;
    @(negedge clk_USB);
    d = rd_data;
  endtask

  task automatic pulse_pe();
    @(negedge clk_USB);
    period_end = 1'b1;
    @(negedge clk_USB);
    period_end = 1'b0;
  endtask

  task automatic set_shadow_a(input logic [18:0] v);
    write_reg(3'd0, v[7:0]);
    write_reg(3'd1, v[15:8]);
    write_reg(3'd2, {5'b0, v[18:16]});
  endtask

  initial begin
    // Reset state
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_cmpa", cmpa, 0);
    check("rst_cmpb", cmpb, 0);
    check("rst_busy", busy, 0);
    check("rst_alert", alert, 0);

    // Shadow isolation
    write_reg(3'd0, 8'h44);
    write_reg(3'd1, 8'h13);
    write_reg(3'd2, 8'hFA);  // upper bits dropped -> 3'b010
    repeat (5) pulse_pe();
    check("iso_cmpa", cmpa, 0);
    read_reg(3'd7, r_rd);
    check("iso_status", r_rd, 8'h00);
    read_reg(3'd2, r_rd);
    check("iso_rd2", r_rd, 8'h02);
    read_reg(3'd0, r_rd);
    check("iso_rd0", r_rd, 8'h44);
    read_reg(3'd3, r_rd);
    check("iso_rd3", r_rd, 8'h00);

    // Immediate commit
    write_reg(3'd2, 8'h00);
    write_reg(3'd3, 8'h81);
    check("imm_busy", busy, 2'b01);
    check("imm_pre", cmpa, 0);
    pulse_pe();
    check("imm_cmpa", cmpa, 19'h01344);
    tick(2);
    check("imm_alert", alert, 1);
    check("imm_busy_done", busy, 0);
    read_reg(3'd7, r_rd);
    check("imm_status", r_rd, 8'h01);
    write_reg(3'd7, 8'h0C);  // busy bits are read-only, done untouched
    check("imm_alert_keep", alert, 1);
    write_reg(3'd7, 8'h01);
    check("imm_w1c", alert, 0);

    // Back to 0, then slew up to 0x01344
    set_shadow_a(19'h0);
    write_reg(3'd3, 8'h81);
    pulse_pe();
    check("zero_cmpa", cmpa, 0);
    tick(1);
    write_reg(3'd7, 8'h01);
    set_shadow_a(19'h01344);
    write_reg(3'd3, 8'h01);
    for (int i = 1; i <= 19; i++) begin
      pulse_pe();
      check($sformatf("slew_%0d", i), cmpa, i * 32'h100);
      check($sformatf("slew_busy_%0d", i), busy[0], 1);
    end
    check("slew_noalert", alert, 0);
    pulse_pe();
    check("slew_final", cmpa, 19'h01344);
    tick(1);
    check("slew_busy_end", busy, 0);
    check("slew_alert", alert, 1);
    write_reg(3'd7, 8'h01);

    // Retarget mid-slew: 0 -> 0x1000, redirected to 0x0400 at 0x0800
    set_shadow_a(19'h0);
    write_reg(3'd3, 8'h81);
    pulse_pe();
    tick(1);
    write_reg(3'd7, 8'h01);
    set_shadow_a(19'h01000);
    write_reg(3'd3, 8'h01);
    repeat (8) pulse_pe();
    check("rt_mid", cmpa, 19'h00800);
    set_shadow_a(19'h00400);
    write_reg(3'd3, 8'h01);
    check("rt_nojump", cmpa, 19'h00800);
    for (int i = 1; i <= 4; i++) begin
      pulse_pe();
      check($sformatf("rt_step_%0d", i), cmpa, 32'h800 - i * 32'h100);
      if (i < 4) check($sformatf("rt_noalert_%0d", i), alert, 0);
    end
    tick(1);
    check("rt_alert", alert, 1);
    write_reg(3'd7, 8'h01);
    repeat (3) pulse_pe();
    check("rt_single_alert", alert, 0);
    check("rt_hold", cmpa, 19'h00400);

    // Collision and clamp on channel B
    write_reg(3'd4, 8'hFF);
    write_reg(3'd5, 8'hFF);
    write_reg(3'd6, 8'hFF);
    read_reg(3'd6, r_rd);
    check("clamp_rd6", r_rd, 8'h07);
    @(negedge clk_USB);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h02; period_end = 1'b1;
    @(negedge clk_USB);
    wr_en = 1'b0; period_end = 1'b0;
    check("col_cmpb", cmpb, 0);
    check("col_busy", busy, 2'b10);
    pulse_pe();
    check("col_step1", cmpb, 19'h00100);
    pulse_pe();
    check("col_step2", cmpb, 19'h00200);
    check("col_cmpa", cmpa, 19'h00400);
    write_reg(3'd3, 8'h82);
    pulse_pe();
    check("clamp_cmpb", cmpb, 19'h40000);
    tick(1);
    check("clamp_alert", alert, 1);
    read_reg(3'd7, r_rd);
    check("clamp_status", r_rd, 8'h02);
    write_reg(3'd7, 8'h02);

    // Reset mid-slew (B slewing down from 0x40000)
    write_reg(3'd4, 8'h00);
    write_reg(3'd5, 8'h00);
    write_reg(3'd6, 8'h00);
    write_reg(3'd3, 8'h02);
    pulse_pe();
    check("down_1", cmpb, 19'h3FF00);
    pulse_pe();
    check("down_2", cmpb, 19'h3FE00);
    check("down_busy", busy, 2'b10);
    @(negedge clk_USB);
    rst_n = 1'b0;
    #1;
    check("mrst_cmpa", cmpa, 0);
    check("mrst_cmpb", cmpb, 0);
    check("mrst_busy", busy, 0);
    check("mrst_alert", alert, 0);
    tick(2);
    rst_n = 1'b1;
    repeat (2) pulse_pe();
    check("mrst_hold", cmpb, 0);
    check("mrst_noalert", alert, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
